// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants, phase encoding and counter-width helper for sipo_rx
package sipo_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SHIFT  = 2'd1,
    PH_PARITY = 2'd2
  } phase_t;

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - shift register with direction mux; SIPO_RX_PARITY_EN selects which value forms the word
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign shreg_next = {serial_in, shreg[WIDTH-1:1]};
    end
  endgenerate

  // With parity the data is complete before the parity bit arrives, so the
  // word is the held register; otherwise it includes the bit being sampled.
`ifdef SIPO_RX_PARITY_EN
  assign word = shreg;
`else
  assign word = shreg_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (shift) begin
      shreg <= shreg_next;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in/parallel-out receiver with valid/ready output; optional parity via SIPO_RX_PARITY_EN
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SIPO_RX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [CW-1:0]    bit_cnt;
  phase_t           phase;
  logic             strobe;
  logic             frame_end;
  logic             shift;
  logic             word_par;
  logic [WIDTH-1:0] word;

  always_comb begin
    phase = PH_SHIFT;
    if (bit_cnt == '0) begin
      phase = PH_IDLE;
    end else if (bit_cnt == CW'(WIDTH)) begin
      phase = PH_PARITY;
    end
  end

  assign strobe    = serial_en & ~clear;
  assign frame_end = strobe & (bit_cnt == CW'(LAST));
  assign shift     = strobe & (phase != PH_PARITY);

`ifdef SIPO_RX_PARITY_EN
  assign word_par = (^word) ^ serial_in;
`else
  assign word_par = 1'b0;
`endif

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift    (shift),
    .serial_in(serial_in),
    .word     (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      if (clear) begin
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (strobe) begin
        bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
      end

      // A completing word may replace one being consumed on the same edge.
      if (frame_end) begin
        if (!out_valid || out_ready) begin
          parallel_out <= word;
          parity_err   <= word_par;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
